// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer: widths, fetch-state encoding
// and instruction field positions.
package mano_pkg;

  localparam int MANO_ADDR_W = 12;
  localparam int MANO_DATA_W = 16;

  // Encoding order is visible on t_state, so it must not be reordered.
  typedef enum logic [1:0] {
    T0_ADDR   = 2'd0,
    T1_READ   = 2'd1,
    T2_DECODE = 2'd2,
    HALTED    = 2'd3
  } fetch_state_e;

  localparam int OPC_MSB = 14;
  localparam int OPC_LSB = 12;
  localparam int I_BIT   = 15;

  localparam logic [2:0] OPC_REG_IO = 3'b111;

endpackage

// File: rtl/mano_fetch_unit.sv
// T0/T1/T2 fetch-decode sequencer: AR<-PC, IR<-M[AR] with PC increment,
// then decode and hand the instruction to execute via valid/ready.
module mano_fetch_unit
  import mano_pkg::*;
#(
  parameter int ADDR_W = MANO_ADDR_W,
  parameter int DATA_W = MANO_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  input  logic              halt,
  input  logic              flush,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        opcode,
  output logic              indirect,
  output logic [1:0]        t_state,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e r_state;
  fetch_state_e w_next;

  logic [ADDR_W-1:0] r_ar;
  logic [DATA_W-1:0] r_ir;
  logic              r_i;
  logic [CNT_W-1:0]  r_fetch_count;

  logic w_pc_inc;
  logic w_mem_rd;
  logic w_valid;
  logic w_ld_ar;
  logic w_hs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= T0_ADDR;
    else        r_state <= w_next;
  end

  // flush outranks everything; in T2 it still lets a coincident ready retire.
  always_comb begin
    w_next   = r_state;
    w_pc_inc = 1'b0;
    w_mem_rd = 1'b0;
    w_valid  = 1'b0;
    w_ld_ar  = 1'b0;
    w_hs     = 1'b0;
    case (r_state)
      T0_ADDR: begin
        if (flush)     w_next = T0_ADDR;
        else if (halt) w_next = HALTED;
        else begin
          w_ld_ar = 1'b1;
          w_next  = T1_READ;
        end
      end
      T1_READ: begin
        w_mem_rd = 1'b1;
        if (flush) w_next = T0_ADDR;
        else if (mem_ack) begin
          w_pc_inc = 1'b1;
          w_next   = T2_DECODE;
        end
      end
      T2_DECODE: begin
        w_valid = 1'b1;
        w_hs    = instr_ready;
        if (flush || instr_ready) w_next = T0_ADDR;
      end
      HALTED: begin
        if (flush || !halt) w_next = T0_ADDR;
      end
      default: w_next = T0_ADDR;
    endcase
  end

  // I and AR decode straight from the incoming word on the T1->T2 edge,
  // so they are valid together with IR in the first T2 cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ar <= '0;
      r_ir <= '0;
      r_i  <= 1'b0;
    end else if (w_ld_ar) begin
      r_ar <= pc_addr;
    end else if (w_pc_inc) begin
      r_ir <= mem_rdata;
      r_i  <= mem_rdata[I_BIT];
      r_ar <= mem_rdata[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_fetch_count <= '0;
    else if (w_hs) r_fetch_count <= r_fetch_count + 1'b1;
  end

  assign pc_inc      = w_pc_inc;
  assign mem_rd      = w_mem_rd;
  assign mem_addr    = r_ar;
  assign instr_valid = w_valid;
  assign ir          = r_ir;
  assign opcode      = r_ir[OPC_MSB:OPC_LSB];
  assign indirect    = r_i;
  assign t_state     = r_state;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_mano_fetch_unit.sv
// Directed bench for mano_fetch_unit with a handshake scoreboard.
module tb_mano_fetch_unit;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_addr;
  logic          pc_inc;
  logic          halt;
  logic          flush;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] ir;
  logic [2:0]    opcode;
  logic          indirect;
  logic [1:0]    t_state;
  logic [CW-1:0] fetch_count;

  mano_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_inc(pc_inc),
    .halt(halt), .flush(flush), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ir(ir), .opcode(opcode), .indirect(indirect),
    .t_state(t_state), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [11:0] ar;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  int exp_inc = 0;
  int seen_inc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    #4;
    if (reset) begin
      if (pc_inc) seen_inc++;
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          chk("hs_ir", ir, e.ir);
          chk("hs_opc", opcode, e.ir[14:12]);
          chk("hs_i", indirect, e.ir[15]);
          chk("hs_ar", mem_addr, e.ar);
        end
      end
    end
  end

  // Entered in T0; leaves in the T0 after the handshake.
  task automatic do_fetch(input logic [11:0] pc, input logic [15:0] d,
                          input int waits, input int rdy_lo, input bit hlt);
    exp_t e;
    pc_addr = pc;
    #1;
    chk("t0_st", t_state, 0);
    chk("t0_rd", mem_rd, 0);
    tick();
    halt = hlt;
    chk("t1_st", t_state, 1);
    for (int w = 0; w < waits; w++) begin
      chk("t1_wait_rd", mem_rd, 1);
      chk("t1_wait_addr", mem_addr, pc);
      chk("t1_wait_noinc", pc_inc, 0);
      tick();
    end
    chk("t1_rd", mem_rd, 1);
    chk("t1_addr", mem_addr, pc);
    mem_ack = 1'b1;
    mem_rdata = d;
    e.ir = d;
    e.ar = d[11:0];
    sb.push_back(e);
    exp_inc++;
    #1;
    chk("t1_inc", pc_inc, 1);
    tick();
    mem_ack = 1'b0;
    mem_rdata = 16'(~d);
    instr_ready = (rdy_lo == 0);
    chk("t2_st", t_state, 2);
    chk("t2_vld", instr_valid, 1);
    chk("t2_noinc", pc_inc, 0);
    chk("t2_ar", mem_addr, d[11:0]);
    for (int r = 0; r < rdy_lo; r++) begin
      tick();
      chk("t2_hold_ir", ir, d);
      chk("t2_hold_v", instr_valid, 1);
      chk("t2_nord", mem_rd, 0);
      chk("t2_cnt_hold", fetch_count, exp_cnt % 16);
      if (r == rdy_lo - 1) instr_ready = 1'b1;
    end
    exp_cnt++;
    tick();
    chk("cnt", fetch_count, exp_cnt % 16);
    chk("back_t0", t_state, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b0; pc_addr = 12'h010; halt = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_st", t_state, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_inc", pc_inc, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_ir", ir, 0);
    chk("rst_i", indirect, 0);
    chk("rst_ar", mem_addr, 0);
    chk("rst_cnt", fetch_count, 0);
    reset = 1'b1;

    do_fetch(12'h010, 16'h7800, 0, 0, 0);
    do_fetch(12'h011, 16'h8123, 4, 0, 0);
    do_fetch(12'h012, 16'h2345, 0, 3, 0);

    // flush coincident with ack in T1: word dropped, no increment
    pc_addr = 12'h013;
    tick();
    chk("fl1_st", t_state, 1);
    mem_ack = 1'b1; mem_rdata = 16'h1234; flush = 1'b1;
    #1;
    chk("fl1_noinc", pc_inc, 0);
    tick();
    flush = 1'b0; mem_ack = 1'b0; pc_addr = 12'h200;
    chk("fl1_t0", t_state, 0);
    chk("fl1_ir", ir, 16'h2345);
    chk("fl1_nord", mem_rd, 0);
    do_fetch(12'h200, 16'h5A5A, 1, 0, 0);

    // flush with ready in T2: handshake still retires
    pc_addr = 12'h201;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h3001;
    e.ir = 16'h3001; e.ar = 12'h001;
    sb.push_back(e);
    exp_inc++;
    tick();
    mem_ack = 1'b0; instr_ready = 1'b1; flush = 1'b1;
    exp_cnt++;
    chk("fl2_vld", instr_valid, 1);
    tick();
    flush = 1'b0;
    chk("fl2_t0", t_state, 0);
    chk("fl2_vld_drop", instr_valid, 0);
    chk("fl2_cnt", fetch_count, exp_cnt % 16);

    // halt raised mid-fetch: fetch completes, then HALTED
    do_fetch(12'h202, 16'h6789, 2, 1, 1);
    tick();
    chk("hlt_st", t_state, 3);
    chk("hlt_nord", mem_rd, 0);
    chk("hlt_nvld", instr_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("hlt_fl_t0", t_state, 0);
    tick();
    chk("hlt_back", t_state, 3);
    halt = 1'b0; pc_addr = 12'h300;
    tick();
    chk("hlt_resume", t_state, 0);
    do_fetch(12'h300, 16'hC0DE, 0, 0, 0);

    // async reset in the middle of a read
    pc_addr = 12'h301;
    tick();
    chk("mr_rd", mem_rd, 1);
    reset = 1'b0;
    #1;
    chk("mr_st", t_state, 0);
    chk("mr_nord", mem_rd, 0);
    chk("mr_ar", mem_addr, 0);
    chk("mr_ir", ir, 0);
    chk("mr_i", indirect, 0);
    chk("mr_cnt", fetch_count, 0);
    chk("mr_vld", instr_valid, 0);
    exp_cnt = 0;
    tick();
    reset = 1'b1;

    // run the counter round its full range and past the wrap
    for (int i = 0; i < 17; i++) begin
      do_fetch(12'($urandom), 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 1), 0);
      if (exp_cnt == 16) chk("wrap", fetch_count, 0);
    end

    #5;
    chk("pcinc_total", seen_inc, exp_inc);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mano_fetch_unit.md
Name: mano_fetch_unit

Overview:
Instruction-fetch sequencer for the Mano basic computer. It sits directly downstream of the program counter, consuming its current address and driving its increment strobe. It implements the T0/T1/T2 fetch-decode cycle: AR<-PC; IR<-M[AR] with PC<-PC+1; then decode, I<-IR[15] and AR<-IR[11:0]. It presents the decoded instruction to the execute control through a valid/ready handshake.

Parameters:
ADDR_W, 12, width of PC/AR and memory address
DATA_W, 16, width of memory word and IR (must be 16; opcode/I positions fixed)
CNT_W, 16, width of retired-fetch counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_addr  in  ADDR_W  current PC value from program counter
pc_inc  out  1  one-cycle increment strobe to program counter
halt  in  1  stop starting new fetches
flush  in  1  branch/interrupt redirect: abandon current fetch, restart from pc_addr
mem_rd  out  1  memory read request
mem_addr  out  ADDR_W  AR register, memory address
mem_ack  in  1  read data valid this cycle
mem_rdata  in  DATA_W  memory read data
instr_valid  out  1  decoded instruction available
instr_ready  in  1  execute control accepts instruction
ir  out  DATA_W  instruction register
opcode  out  3  IR[14:12]
indirect  out  1  I flip-flop (IR[15])
t_state  out  2  0=T0, 1=T1, 2=T2, 3=halted
fetch_count  out  CNT_W  completed handshakes, wraps

Behaviour:
- Reset (reset low, async): state=T0, AR=0, IR=0, I=0, fetch_count=0; all strobes/valid low. Outputs remain at these values while reset is low.
- States: T0_ADDR, T1_READ, T2_DECODE, HALTED. t_state encodes them in that order.
- T0_ADDR: if halt, go to HALTED. Otherwise AR<=pc_addr and go to T1_READ.
- T1_READ:
  - mem_rd=1 and mem_addr=AR, both held stable until mem_ack.
  - On mem_ack (and no flush): IR<=mem_rdata, pc_inc=1 combinationally in that same cycle (exactly one cycle), then go to T2_DECODE.
  - Without mem_ack: stay in T1_READ; no timeout.
- T2_DECODE:
  - On entry edge: I<=IR[15] and AR<=IR[11:0]. Both are registered from the captured word.
  - instr_valid=1 from the first T2 cycle. ir, opcode and indirect are held stable while valid.
  - On instr_valid&instr_ready: fetch_count++ (wraps at 2^CNT_W-1 to 0), go to T0_ADDR.
- HALTED: when halt deasserts, go to T0_ADDR. mem_rd, pc_inc and instr_valid stay low while halted.
- Latency: with zero-wait memory (mem_ack in the first T1 cycle) and ready high, one instruction every 3 cycles; instr_valid is asserted 2 cycles after T0.
- flush (highest priority, any state): next state T0_ADDR.
  - In T1_READ: mem_rd drops next cycle. A coincident mem_ack is discarded: IR unchanged, pc_inc=0.
  - In T2_DECODE: instr_valid drops next cycle. A coincident ready still counts the handshake (fetch_count++).
  - In HALTED: the flush overrides halt for one T0 visit; if halt is still high in T0, the block returns to HALTED.
  - The PC loads its new value on the flush edge, so the T0 that follows samples the redirected address.
- halt only takes effect in T0. A fetch already in T1 or T2 completes normally.
- pc_inc is never asserted outside T1_READ.
- Simultaneous pc_inc and an external PC load are avoided by the flush rule above.
- mem_ack outside T1_READ is ignored.
- Reset mid-fetch: immediate return to reset values; any in-flight memory read is abandoned. Memory must tolerate the request dropping.

Decomposition:
- Shared package mano_pkg holds:
  - ADDR_W and DATA_W defaults
  - state encoding constants T0_ADDR/T1_READ/T2_DECODE/HALTED
  - opcode field positions [14:12] and I-bit position [15]
  - opcode value 3'b111 (register/IO reference), for downstream use
- No sub-module is needed. The fetch_count counter is inline; it is a simple wrapping register.

Test Plan:
- Reset release, pc_addr=0x010, mem returns 0x7800 with zero wait, ready=1 → T0,T1,T2 in consecutive cycles; mem_addr=0x010; one pc_inc pulse in T1; ir=0x7800, opcode=7, indirect=0; AR=0x800; fetch_count=1.
- mem_ack delayed 4 cycles, mem_rdata=0x8123 → mem_rd and mem_addr held for 5 cycles; single pc_inc only on the ack cycle; indirect=1, opcode=0, AR=0x123.
- instr_ready low 3 cycles in T2 → instr_valid and ir stable throughout; no new mem_rd; fetch_count increments once on the handshake.
- flush coincident with mem_ack in T1 → no pc_inc, IR retains its old value, next state T0 sampling the new pc_addr=0x200.
- halt high during T1 → current fetch completes and is handed off; next T0 goes to HALTED (t_state=3) with no mem_rd; halt low → fetch resumes at the current pc_addr.
- Reset asserted mid-T1 → all outputs return to reset values immediately (asynchronously); fetch_count at 0xFFFF wraps to 0 on the next handshake.
